bkt_ctrl: RTL and testbench

//   Backtrack controller for the state_list. It is the counterpart of the decision unit:

---
 rtl/bkt_ctrl.sv | 146 ++++++++++++++
 tb/tb_bkt_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bkt_ctrl.sv
// Purpose: on a conflict, scans every variable and computes the chronological backtrack level, clear mask and flip mask.
// Latency: a conflict accepted at edge T gives the apply/done pulse NUM_VARS+1 cycles later; a level-0 conflict gives the unsat pulse one cycle later.
// Backpressure: none; conflict_pulse is only taken in IDLE, is dropped while busy or unsat, and is never queued.
module bkt_ctrl #(
    parameter int NUM_VARS  = 8,
    parameter int WIDTH_LVL = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          conflict_pulse,
    input  logic [WIDTH_LVL-1:0]          cur_lvl_i,
    input  logic [NUM_VARS*3-1:0]         vars_value_i,
    input  logic [NUM_VARS*WIDTH_LVL-1:0] vars_lvl_i,
    output logic                          apply_bkt_o,
    output logic [WIDTH_LVL-1:0]          bkt_lvl_o,
    output logic [NUM_VARS-1:0]           clear_mask_o,
    output logic [NUM_VARS-1:0]           flip_index_o,
    output logic                          bkt_done,
    output logic                          unsat_o,
    output logic                          busy_o
);

    localparam int IDX_W = (NUM_VARS > 1) ? $clog2(NUM_VARS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VARS - 1);

    // UNSAT_REPORT carries the one-cycle done pulse; UNSAT is the terminal resting state.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_APPLY,
        ST_UNSAT_REPORT,
        ST_UNSAT
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [IDX_W-1:0]      idx;
    logic [WIDTH_LVL-1:0]  lvl_q;
    logic [NUM_VARS-1:0]   clr_acc;
    logic [NUM_VARS-1:0]   flip_acc;
    logic [NUM_VARS-1:0]   clr_nxt;
    logic [NUM_VARS-1:0]   flip_nxt;

    logic [2:0]            val_arr [NUM_VARS];
    logic [WIDTH_LVL-1:0]  lvl_arr [NUM_VARS];
    logic [2:0]            cur_val;
    logic [WIDTH_LVL-1:0]  cur_var_lvl;
    logic                  cur_assigned;
    logic                  cur_is_dec;

    // Split the flat per-variable buses into arrays so the scan can index by idx.
    for (genvar g = 0; g < NUM_VARS; g++) begin : g_unpack
        assign val_arr[g] = vars_value_i[g*3 +: 3];
        assign lvl_arr[g] = vars_lvl_i[g*WIDTH_LVL +: WIDTH_LVL];
    end

    assign cur_val      = val_arr[idx];
    assign cur_var_lvl  = lvl_arr[idx];
    assign cur_assigned = (cur_val[1:0] != 2'b00);
    assign cur_is_dec   = cur_val[2];

    // State register; reset aborts any scan in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Scan datapath: latch L and clear the accumulators on accept; step one variable per cycle in SCAN.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx      <= '0;
            lvl_q    <= '0;
            clr_acc  <= '0;
            flip_acc <= '0;
        end else if (state == ST_IDLE && conflict_pulse) begin
            idx      <= '0;
            lvl_q    <= cur_lvl_i;
            clr_acc  <= '0;
            flip_acc <= '0;
        end else if (state == ST_SCAN) begin
            idx      <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
            clr_acc  <= clr_nxt;
            flip_acc <= flip_nxt;
        end
    end

    // Next-state, accumulator update and outputs; outputs stay 0 outside their valid cycle.
    always_comb begin
        state_nxt    = state;
        clr_nxt      = clr_acc;
        flip_nxt     = flip_acc;
        apply_bkt_o  = 1'b0;
        bkt_lvl_o    = '0;
        clear_mask_o = '0;
        flip_index_o = '0;
        bkt_done     = 1'b0;
        unsat_o      = 1'b0;
        busy_o       = 1'b0;
        case (state)
            ST_IDLE: begin
                // Level 0 has nothing to back out of, so it goes straight to unsat.
                if (conflict_pulse) begin
                    state_nxt = (cur_lvl_i != '0) ? ST_SCAN : ST_UNSAT_REPORT;
                end
            end
            ST_SCAN: begin
                busy_o = 1'b1;
                if (cur_assigned && (cur_var_lvl >= lvl_q)) begin
                    clr_nxt[idx] = 1'b1;
                end
                // Only the first decision found at L is flipped, so the lowest index wins.
                if (cur_assigned && cur_is_dec && (cur_var_lvl == lvl_q) && (flip_acc == '0)) begin
                    flip_nxt[idx] = 1'b1;
                end
                if (idx == LAST_IDX) begin
                    state_nxt = (flip_nxt != '0) ? ST_APPLY : ST_UNSAT_REPORT;
                end
            end
            ST_APPLY: begin
                busy_o       = 1'b1;
                apply_bkt_o  = 1'b1;
                bkt_done     = 1'b1;
                bkt_lvl_o    = lvl_q;
                clear_mask_o = clr_acc;
                flip_index_o = flip_acc;
                state_nxt    = ST_IDLE;
            end
            ST_UNSAT_REPORT: begin
                busy_o    = 1'b1;
                bkt_done  = 1'b1;
                unsat_o   = 1'b1;
                state_nxt = ST_UNSAT;
            end
            ST_UNSAT: begin
                unsat_o = 1'b1;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_bkt_ctrl.sv
// Purpose: self-checking bench for bkt_ctrl, with directed cases plus random transactions scored against a reference model.
// Latency: each transaction observes 14 falling-edge samples after the conflict edge.
// Backpressure: the bench drives conflicts only when the model expects the block to be idle or unsat.
module tb_bkt_ctrl;
    localparam int NV = 8;
    localparam int WL = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              conflict_pulse = 1'b0;
    logic [WL-1:0]     cur_lvl_i = '0;
    logic [NV*3-1:0]   vars_value_i = '0;
    logic [NV*WL-1:0]  vars_lvl_i = '0;
    logic              apply_bkt_o;
    logic [WL-1:0]     bkt_lvl_o;
    logic [NV-1:0]     clear_mask_o;
    logic [NV-1:0]     flip_index_o;
    logic              bkt_done;
    logic              unsat_o;
    logic              busy_o;

    int checks = 0;
    int errors = 0;
    bit model_unsat = 1'b0;

    logic [1:0]    m_val [NV];
    logic          m_dec [NV];
    logic [WL-1:0] m_lvl [NV];

    bkt_ctrl #(.NUM_VARS(NV), .WIDTH_LVL(WL)) dut (
        .clk            (clk),
        .rst            (rst),
        .conflict_pulse (conflict_pulse),
        .cur_lvl_i      (cur_lvl_i),
        .vars_value_i   (vars_value_i),
        .vars_lvl_i     (vars_lvl_i),
        .apply_bkt_o    (apply_bkt_o),
        .bkt_lvl_o      (bkt_lvl_o),
        .clear_mask_o   (clear_mask_o),
        .flip_index_o   (flip_index_o),
        .bkt_done       (bkt_done),
        .unsat_o        (unsat_o),
        .busy_o         (busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_vars();
        for (int i = 0; i < NV; i++) begin
            m_val[i] = 2'b00;
            m_dec[i] = 1'b0;
            m_lvl[i] = '0;
        end
    endtask

    task automatic set_var(input int i, input logic [1:0] v, input logic d, input logic [WL-1:0] l);
        m_val[i] = v;
        m_dec[i] = d;
        m_lvl[i] = l;
    endtask

    task automatic drive_vars();
        for (int i = 0; i < NV; i++) begin
            vars_value_i[i*3 +: 3]   = {m_dec[i], m_val[i]};
            vars_lvl_i[i*WL +: WL]   = m_lvl[i];
        end
    endtask

    // Reference: clear every assigned var at or above L; flip the lowest-index decision exactly at L.
    task automatic model(input logic [WL-1:0] L, output logic [NV-1:0] e_clr, output logic [NV-1:0] e_flip);
        bit found;
        e_clr  = '0;
        e_flip = '0;
        found  = 1'b0;
        for (int i = 0; i < NV; i++) begin
            if (m_val[i] != 2'b00 && m_lvl[i] >= L) e_clr[i] = 1'b1;
            if (!found && m_val[i] != 2'b00 && m_dec[i] && m_lvl[i] == L) begin
                e_flip[i] = 1'b1;
                found     = 1'b1;
            end
        end
    endtask

    task automatic run_bkt(input logic [WL-1:0] L, input int inj_at, input string tag);
        logic [NV-1:0] e_clr, e_flip, g_clr, g_flip;
        logic [WL-1:0] g_lvl;
        bit was_unsat, exp_apply;
        int apply_n, apply_at, done_n, done_at, stray;
        logic busy1;
        apply_n = 0; apply_at = 0; done_n = 0; done_at = 0; stray = 0;
        g_clr = '0; g_flip = '0; g_lvl = '0; busy1 = 1'b0;
        model(L, e_clr, e_flip);
        was_unsat = model_unsat;
        exp_apply = !was_unsat && (L != '0) && (e_flip != '0);
        cur_lvl_i = L;
        drive_vars();
        @(negedge clk);
        conflict_pulse = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            conflict_pulse = (k == inj_at);
            if (k == 1) busy1 = busy_o;
            if (apply_bkt_o) begin
                apply_n++;
                if (apply_at == 0) begin
                    apply_at = k;
                    g_lvl    = bkt_lvl_o;
                    g_clr    = clear_mask_o;
                    g_flip   = flip_index_o;
                end
            end else if (clear_mask_o != '0 || flip_index_o != '0 || bkt_lvl_o != '0) begin
                stray++;
            end
            if (bkt_done) begin
                done_n++;
                if (done_at == 0) done_at = k;
            end
        end
        check({tag, ".apply_n"}, 32'(apply_n), exp_apply ? 32'd1 : 32'd0);
        check({tag, ".done_n"}, 32'(done_n), was_unsat ? 32'd0 : 32'd1);
        check({tag, ".unsat"}, 32'(unsat_o), 32'(was_unsat || !exp_apply));
        check({tag, ".busy1"}, 32'(busy1), 32'(!was_unsat));
        check({tag, ".busy_end"}, 32'(busy_o), 32'd0);
        check({tag, ".stray"}, 32'(stray), 32'd0);
        if (exp_apply) begin
            check({tag, ".apply_at"}, 32'(apply_at), 32'(NV + 1));
            check({tag, ".done_at"}, 32'(done_at), 32'(NV + 1));
            check({tag, ".bkt_lvl"}, 32'(g_lvl), 32'(L));
            check({tag, ".clear"}, 32'(g_clr), 32'(e_clr));
            check({tag, ".flip"}, 32'(g_flip), 32'(e_flip));
        end else if (!was_unsat) begin
            check({tag, ".done_at"}, 32'(done_at), (L == '0) ? 32'd1 : 32'(NV + 1));
        end
        model_unsat = was_unsat || !exp_apply;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        model_unsat = 1'b0;
    endtask

    initial begin
        int apply_seen, done_seen;
        logic [WL-1:0] rl;
        int j;
        clear_vars();
        drive_vars();
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst.apply", 32'(apply_bkt_o), 32'd0);
        check("rst.done", 32'(bkt_done), 32'd0);
        check("rst.unsat", 32'(unsat_o), 32'd0);
        check("rst.busy", 32'(busy_o), 32'd0);
        check("rst.masks", 32'({clear_mask_o, flip_index_o}), 32'd0);
        check("rst.lvl", 32'(bkt_lvl_o), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Basic backtrack
        clear_vars();
        set_var(2, 2'b10, 1'b1, 16'd3);
        set_var(5, 2'b01, 1'b0, 16'd3);
        set_var(1, 2'b01, 1'b1, 16'd2);
        set_var(7, 2'b00, 1'b1, 16'd9);
        run_bkt(16'd3, 0, "basic");

        // Two decisions at L: lowest index flips
        clear_vars();
        set_var(3, 2'b01, 1'b1, 16'd2);
        set_var(6, 2'b10, 1'b1, 16'd2);
        set_var(0, 2'b10, 1'b1, 16'd1);
        run_bkt(16'd2, 0, "two_dec");

        // Maximum level, with a free var at the same level that must be ignored
        clear_vars();
        set_var(0, 2'b10, 1'b1, 16'hFFFF);
        set_var(4, 2'b00, 1'b1, 16'hFFFF);
        set_var(5, 2'b01, 1'b0, 16'hFFFE);
        run_bkt(16'hFFFF, 0, "max_lvl");

        // Conflict during SCAN cycle 4 is dropped
        clear_vars();
        set_var(2, 2'b10, 1'b1, 16'd3);
        set_var(5, 2'b01, 1'b0, 16'd3);
        set_var(1, 2'b01, 1'b1, 16'd2);
        run_bkt(16'd3, 4, "busy_ign");

        // Reset at SCAN cycle 5 aborts with no apply afterwards
        cur_lvl_i = 16'd3;
        drive_vars();
        @(negedge clk);
        conflict_pulse = 1'b1;
        @(negedge clk);
        conflict_pulse = 1'b0;
        repeat (4) @(negedge clk);
        check("midrst.busy_before", 32'(busy_o), 32'd1);
        rst = 1'b0;
        #1;
        check("midrst.busy", 32'(busy_o), 32'd0);
        check("midrst.outs", 32'({apply_bkt_o, bkt_done, unsat_o, clear_mask_o, flip_index_o}), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        apply_seen = 0;
        done_seen  = 0;
        repeat (14) begin
            @(negedge clk);
            if (apply_bkt_o) apply_seen++;
            if (bkt_done) done_seen++;
        end
        check("midrst.apply_after", 32'(apply_seen), 32'd0);
        check("midrst.done_after", 32'(done_seen), 32'd0);

        // Random transactions, each guaranteed a decision at L
        for (int t = 0; t < 20; t++) begin
            rl = (t % 3 == 0) ? WL'($urandom_range(32768, 65535)) : WL'($urandom_range(1, 20));
            for (int i = 0; i < NV; i++) begin
                set_var(i, 2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                        rl ^ WL'($urandom_range(0, 3)));
            end
            j = $urandom_range(0, NV - 1);
            set_var(j, 2'($urandom_range(1, 2)), 1'b1, rl);
            run_bkt(rl, 0, $sformatf("rand%0d", t));
        end

        // No decision var at L: unsat after the scan, then further conflicts ignored
        clear_vars();
        set_var(1, 2'b01, 1'b0, 16'd4);
        set_var(3, 2'b10, 1'b0, 16'd4);
        set_var(6, 2'b10, 1'b1, 16'd3);
        run_bkt(16'd4, 0, "no_dec");
        run_bkt(16'd4, 0, "no_dec_again");

        // Reset clears unsat; level 0 conflict goes unsat immediately
        do_reset();
        @(negedge clk);
        check("unsat_rst", 32'(unsat_o), 32'd0);
        clear_vars();
        set_var(0, 2'b10, 1'b1, 16'd0);
        run_bkt(16'd0, 0, "lvl0");
        clear_vars();
        set_var(2, 2'b10, 1'b1, 16'd3);
        run_bkt(16'd3, 0, "lvl0_again");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
